// File: rtl/pipeline2_if.sv
// Decode-stage bus: fetch-side inputs, writeback port and registered execute-side outputs.
// Handshake: done_in qualifies instr/pc_in for one cycle and done qualifies the outputs; there is no ready, the stage never stalls.
interface pipeline2_if #(
   parameter int INSTR_WIDTH    = 32,
   parameter int PC_WIDTH       = 16,
   parameter int DATA_WIDTH     = 16,
   parameter int REG_ADDR_WIDTH = 4
);
   logic                      pc_chg;
   logic                      done_in;
   logic [INSTR_WIDTH-1:0]    instr;
   logic [PC_WIDTH-1:0]       pc_in;
   logic                      wb_we;
   logic [REG_ADDR_WIDTH-1:0] wb_addr;
   logic [DATA_WIDTH-1:0]     wb_data;
   logic [5:0]                opcode;
   logic [REG_ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0]     rs_val;
   logic [DATA_WIDTH-1:0]     rt_val;
   logic [DATA_WIDTH-1:0]     imm_ext;
   logic [PC_WIDTH-1:0]       pc_out;
   logic                      done;

   modport master (
      output pc_chg, done_in, instr, pc_in, wb_we, wb_addr, wb_data,
      input  opcode, rd_addr, rs_val, rt_val, imm_ext, pc_out, done
   );

   modport slave (
      input  pc_chg, done_in, instr, pc_in, wb_we, wb_addr, wb_data,
      output opcode, rd_addr, rs_val, rt_val, imm_ext, pc_out, done
   );
endinterface

// File: rtl/pipeline2.sv
// Decode / register-read stage: field decode, 2-read 1-write register file, registered outputs.
// Optional write-through forwarding on same-edge read/write when REG_BYPASS_EN is defined.
module pipeline2 #(
   parameter int INSTR_WIDTH    = 32,
   parameter int PC_WIDTH       = 16,
   parameter int DATA_WIDTH     = 16,
   parameter int REG_ADDR_WIDTH = 4
) (
   input  logic       clk_in,
   input  logic       RST,
   pipeline2_if.slave bus
);
   localparam int DEPTH = 2 ** REG_ADDR_WIDTH;

   logic [5:0]                dec_op;
   logic [REG_ADDR_WIDTH-1:0] dec_rd;
   logic [REG_ADDR_WIDTH-1:0] dec_rs;
   logic [REG_ADDR_WIDTH-1:0] dec_rt;
   logic [DATA_WIDTH-1:0]     dec_imm;
   logic                      wr_en;
   logic [DATA_WIDTH-1:0]     rs_rd;
   logic [DATA_WIDTH-1:0]     rt_rd;
   logic [DATA_WIDTH-1:0]     rf [DEPTH];

   assign dec_op  = bus.instr[31:26];
   assign dec_rd  = bus.instr[22 +: REG_ADDR_WIDTH];
   assign dec_rs  = bus.instr[18 +: REG_ADDR_WIDTH];
   assign dec_rt  = bus.instr[14 +: REG_ADDR_WIDTH];
   // Sized cast of a signed 14-bit field sign-extends (or truncates) to DATA_WIDTH.
   assign dec_imm = DATA_WIDTH'($signed(bus.instr[13:0]));
   assign wr_en   = bus.wb_we && (bus.wb_addr != '0);

   always_comb begin
      rs_rd = '0;
      rt_rd = '0;
      if (dec_rs != '0) rs_rd = rf[dec_rs];
      if (dec_rt != '0) rt_rd = rf[dec_rt];
`ifdef REG_BYPASS_EN
      if (wr_en && (bus.wb_addr == dec_rs)) rs_rd = bus.wb_data;
      if (wr_en && (bus.wb_addr == dec_rt)) rt_rd = bus.wb_data;
`endif
   end

   // The write still commits during a flush; only the stage output is squashed.
   always_ff @(posedge clk_in or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      end else if (wr_en) begin
         rf[bus.wb_addr] <= bus.wb_data;
      end
   end

   always_ff @(posedge clk_in or negedge RST) begin
      if (!RST) begin
         bus.opcode  <= '0;
         bus.rd_addr <= '0;
         bus.rs_val  <= '0;
         bus.rt_val  <= '0;
         bus.imm_ext <= '0;
         bus.pc_out  <= '0;
         bus.done    <= 1'b0;
      end else if (bus.pc_chg || !bus.done_in) begin
         // Flush and bubble look identical downstream: a NOP with done low, operands held.
         bus.opcode  <= '0;
         bus.rd_addr <= '0;
         bus.done    <= 1'b0;
      end else begin
         bus.opcode  <= dec_op;
         bus.rd_addr <= dec_rd;
         bus.rs_val  <= rs_rd;
         bus.rt_val  <= rt_rd;
         bus.imm_ext <= dec_imm;
         bus.pc_out  <= bus.pc_in;
         bus.done    <= 1'b1;
      end
   end
endmodule

// File: tb/tb_pipeline2.sv
// Bench for pipeline2: directed vector table, reset sequences, and random traffic checked
// against an array-based register-file model of the decode stage.
module tb_pipeline2;
   localparam int OW = 1 + 6 + 4 + 16 + 16 + 16 + 16;

   logic clk_in = 1'b0;
   logic RST    = 1'b0;
   always #5 clk_in = ~clk_in;

   pipeline2_if bus ();
   pipeline2 dut (.clk_in(clk_in), .RST(RST), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model state: register contents and the last presented outputs.
   logic [15:0]   m_rf [16];
   logic [OW-1:0] m_out;
   logic [OW-1:0] exp_q [$];

   typedef struct {
      logic        pc_chg;
      logic        done_in;
      logic [31:0] instr;
      logic [15:0] pc_in;
      logic        wb_we;
      logic [3:0]  wb_addr;
      logic [15:0] wb_data;
      logic        e_done;
      logic [5:0]  e_op;
      logic [3:0]  e_rd;
      logic [15:0] e_rs;
      logic [15:0] e_rt;
      logic [15:0] e_imm;
      logic [15:0] e_pc;
   } vec_t;

   vec_t tbl [11];

   function automatic logic [31:0] mk_instr(int op, int rd, int rs, int rt, int imm);
      return (op * 32'h0400_0000) + (rd * 32'h0040_0000) + (rs * 32'h0004_0000)
             + (rt * 32'h0000_4000) + (imm % 16384);
   endfunction

   function automatic vec_t mkv(logic pc_chg, logic done_in, logic [31:0] instr, logic [15:0] pc_in,
                                logic wb_we, logic [3:0] wb_addr, logic [15:0] wb_data,
                                logic e_done, logic [5:0] e_op, logic [3:0] e_rd,
                                logic [15:0] e_rs, logic [15:0] e_rt, logic [15:0] e_imm,
                                logic [15:0] e_pc);
      vec_t v;
      v.pc_chg = pc_chg; v.done_in = done_in; v.instr = instr; v.pc_in = pc_in;
      v.wb_we = wb_we; v.wb_addr = wb_addr; v.wb_data = wb_data;
      v.e_done = e_done; v.e_op = e_op; v.e_rd = e_rd; v.e_rs = e_rs; v.e_rt = e_rt;
      v.e_imm = e_imm; v.e_pc = e_pc;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_outs(string tag, logic [OW-1:0] e);
      chk({tag, ".done"},    32'(bus.done),    32'(e[74]));
      chk({tag, ".opcode"},  32'(bus.opcode),  32'(e[73:68]));
      chk({tag, ".rd_addr"}, 32'(bus.rd_addr), 32'(e[67:64]));
      chk({tag, ".rs_val"},  32'(bus.rs_val),  32'(e[63:48]));
      chk({tag, ".rt_val"},  32'(bus.rt_val),  32'(e[47:32]));
      chk({tag, ".imm_ext"}, 32'(bus.imm_ext), 32'(e[31:16]));
      chk({tag, ".pc_out"},  32'(bus.pc_out),  32'(e[15:0]));
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) m_rf[i] = '0;
      m_out = '0;
      exp_q.delete();
   endfunction

   // Expected outputs for one rising edge, derived from the field layout and the write rules.
   function automatic void model_edge();
      int          rs, rt, imm;
      logic [15:0] rsv, rtv;
      logic        wr;
      rs  = int'(bus.instr[21:18]);
      rt  = int'(bus.instr[17:14]);
      wr  = bus.wb_we && (bus.wb_addr != 0);
      rsv = m_rf[rs];
      rtv = m_rf[rt];
`ifdef REG_BYPASS_EN
      if (wr && int'(bus.wb_addr) == rs) rsv = bus.wb_data;
      if (wr && int'(bus.wb_addr) == rt) rtv = bus.wb_data;
`endif
      if (bus.pc_chg || !bus.done_in) begin
         m_out[74]    = 1'b0;
         m_out[73:64] = '0;
      end else begin
         imm = int'(bus.instr[13:0]);
         if (imm >= 8192) imm = imm - 16384;
         m_out = {1'b1, bus.instr[31:26], bus.instr[25:22], rsv, rtv, 16'(imm), bus.pc_in};
      end
      if (wr) m_rf[bus.wb_addr] = bus.wb_data;
      exp_q.push_back(m_out);
   endfunction

   task automatic drive(logic pc_chg, logic done_in, logic [31:0] instr, logic [15:0] pc_in,
                        logic wb_we, logic [3:0] wb_addr, logic [15:0] wb_data);
      bus.pc_chg = pc_chg; bus.done_in = done_in; bus.instr = instr; bus.pc_in = pc_in;
      bus.wb_we = wb_we; bus.wb_addr = wb_addr; bus.wb_data = wb_data;
   endtask

   // One clock: inputs already driven, predict, clock, then compare 1 ns after the edge.
   task automatic step(string tag);
      logic [OW-1:0] e;
      model_edge();
      @(posedge clk_in);
      #1;
      if (exp_q.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL %s.queue: got empty expected entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk_outs(tag, e);
      end
   endtask

   task automatic drive_random();
      drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), $urandom(),
            16'($urandom()), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom()));
   endtask

   initial begin
      logic [15:0] haz;
      drive_random();
      model_reset();

      // Reset held with random inputs toggling underneath.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_in);
         #1;
         drive_random();
         bus.wb_we = 1'b1;
         chk_outs("reset_hold", '0);
      end
      RST = 1'b1;

      // Every register reads zero after reset.
      for (int r = 1; r < 16; r++) begin
         drive(1'b0, 1'b1, mk_instr(r, r, r, 16 - r, r * 3), 16'(r * 4), 1'b0, 4'd0, 16'd0);
         step("rf_clear");
      end

      // Asynchronous mid-stream reset with a write pending to r9.
      drive(1'b0, 1'b1, mk_instr(6'h2A, 1, 9, 9, 5), 16'h0ABC, 1'b1, 4'd9, 16'h7777);
      #2 RST = 1'b0;
      #1 chk_outs("async_reset", '0);
      @(posedge clk_in);
      #1;
      chk_outs("reset_edge", '0);
      RST = 1'b1;
      model_reset();
      drive(1'b0, 1'b1, mk_instr(0, 0, 9, 9, 0), 16'h0000, 1'b0, 4'd0, 16'd0);
      step("r9_discarded");

`ifdef REG_BYPASS_EN
      haz = 16'hA5A5;
`else
      haz = 16'h0001;
`endif
      tbl[0]  = mkv(0, 0, mk_instr(7, 7, 7, 7, 7),            16'h0F00, 1, 4'd3, 16'h1234,
                    0, 6'h00, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      tbl[1]  = mkv(0, 0, mk_instr(7, 7, 7, 7, 7),            16'h0F04, 1, 4'd5, 16'h00FF,
                    0, 6'h00, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      tbl[2]  = mkv(0, 1, mk_instr(6'h05, 2, 3, 5, 14'h2001), 16'h0104, 0, 4'd0, 16'h0000,
                    1, 6'h05, 4'd2, 16'h1234, 16'h00FF, 16'hE001, 16'h0104);
      tbl[3]  = mkv(1, 1, mk_instr(6'h3F, 9, 5, 3, 14'h0010), 16'h0200, 1, 4'd7, 16'h0001,
                    0, 6'h00, 4'd0, 16'h1234, 16'h00FF, 16'hE001, 16'h0104);
      tbl[4]  = mkv(0, 1, mk_instr(6'h3F, 9, 5, 7, 14'h0010), 16'h0204, 0, 4'd0, 16'h0000,
                    1, 6'h3F, 4'd9, 16'h00FF, 16'h0001, 16'h0010, 16'h0204);
      tbl[5]  = mkv(0, 0, mk_instr(6'h11, 1, 3, 3, 14'h0005), 16'h0208, 0, 4'd0, 16'h0000,
                    0, 6'h00, 4'd0, 16'h00FF, 16'h0001, 16'h0010, 16'h0204);
      tbl[6]  = mkv(0, 0, mk_instr(6'h12, 2, 3, 3, 14'h0006), 16'h020C, 0, 4'd0, 16'h0000,
                    0, 6'h00, 4'd0, 16'h00FF, 16'h0001, 16'h0010, 16'h0204);
      tbl[7]  = mkv(0, 1, mk_instr(6'h01, 1, 0, 0, 14'h1FFF), 16'h0300, 1, 4'd0, 16'hBEEF,
                    1, 6'h01, 4'd1, 16'h0000, 16'h0000, 16'h1FFF, 16'h0300);
      tbl[8]  = mkv(0, 1, mk_instr(6'h02, 3, 0, 3, 14'h3FFF), 16'h0304, 0, 4'd0, 16'h0000,
                    1, 6'h02, 4'd3, 16'h0000, 16'h1234, 16'hFFFF, 16'h0304);
      tbl[9]  = mkv(0, 1, mk_instr(6'h04, 4, 7, 7, 14'h0000), 16'h0308, 1, 4'd7, 16'hA5A5,
                    1, 6'h04, 4'd4, haz, haz, 16'h0000, 16'h0308);
      tbl[10] = mkv(0, 1, mk_instr(6'h04, 5, 7, 0, 14'h2000), 16'h030C, 0, 4'd0, 16'h0000,
                    1, 6'h04, 4'd5, 16'hA5A5, 16'h0000, 16'hE000, 16'h030C);

      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].pc_chg, tbl[i].done_in, tbl[i].instr, tbl[i].pc_in,
               tbl[i].wb_we, tbl[i].wb_addr, tbl[i].wb_data);
         step($sformatf("model_vec%0d", i));
         chk_outs($sformatf("vec%0d", i),
                  {tbl[i].e_done, tbl[i].e_op, tbl[i].e_rd, tbl[i].e_rs, tbl[i].e_rt,
                   tbl[i].e_imm, tbl[i].e_pc});
      end

      // Random traffic with one asynchronous reset dropped in partway.
      for (int c = 0; c < 400; c++) begin
         drive_random();
         if (c == 200) begin
            #3 RST = 1'b0;
            #1 chk_outs("rand_async_reset", '0);
            @(posedge clk_in);
            #1;
            RST = 1'b1;
            model_reset();
         end else begin
            step("rand");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
